// File: rtl/iob_ibex_axi_pkg.sv
// AXI4 encodings shared by the Ibex OBI-to-AXI bridges.
package iob_ibex_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_W32   = 3'b010;
    localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
    localparam logic [2:0] AXI_PROT_DATA  = 3'b000;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    // SLVERR and DECERR both have the upper bit set; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/iob_ibex_obi2axi_if.sv
// AXI4 master port of the Ibex bridge; the word address is ADDR_W-2 bits wide.
interface iob_ibex_obi2axi_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8
);
    localparam int AW = ADDR_W - 2;

    logic                 arvalid, arready;
    logic [AW-1:0]        araddr;
    logic [AXI_ID_W-1:0]  arid;
    logic [AXI_LEN_W-1:0] arlen;
    logic [2:0]           arsize, arprot;
    logic [1:0]           arburst;
    logic                 arlock;
    logic [3:0]           arcache, arqos;

    logic                 rvalid, rready, rlast;
    logic [DATA_W-1:0]    rdata;
    logic [1:0]           rresp;
    logic [AXI_ID_W-1:0]  rid;

    logic                 awvalid, awready;
    logic [AW-1:0]        awaddr;
    logic [AXI_ID_W-1:0]  awid;
    logic [AXI_LEN_W-1:0] awlen;
    logic [2:0]           awsize, awprot;
    logic [1:0]           awburst;
    logic                 awlock;
    logic [3:0]           awcache, awqos;

    logic                 wvalid, wready, wlast;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W/8-1:0]  wstrb;

    logic                 bvalid, bready;
    logic [1:0]           bresp;
    logic [AXI_ID_W-1:0]  bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arqos, arprot,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awqos, awprot,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arqos, arprot,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awqos, awprot,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface

// File: rtl/iob_ibex_resp_fifo.sv
// Order tracker for outstanding bus transactions: one bit per entry, 1 = write.
module iob_ibex_resp_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic head_o,
    output logic empty_o,
    output logic full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic [DEPTH-1:0] mem_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_i && !pop_i) begin
            empty_d = 1'b0;
            full_d  = (wr_ptr_d == rd_ptr_q);
        end else if (pop_i && !push_i) begin
            full_d  = 1'b0;
            empty_d = (rd_ptr_d == wr_ptr_q);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Payload needs no reset: it is only observed while the empty flag is low.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Hsiao (39,32) SECDED encoder with inverted check bits, as used by Ibex bus integrity.
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);
    always_comb begin
        data_o     = 39'(data_i);
        data_o[32] = ^(data_o & 39'h002606BD25);
        data_o[33] = ^(data_o & 39'h00DEBA8050);
        data_o[34] = ^(data_o & 39'h00413D89AA);
        data_o[35] = ^(data_o & 39'h0031234ED1);
        data_o[36] = ^(data_o & 39'h00C2C1323B);
        data_o[37] = ^(data_o & 39'h002DCC624C);
        data_o[38] = ^(data_o & 39'h0098505586);
        data_o     = data_o ^ 39'h2A00000000;
    end
endmodule

// File: rtl/iob_ibex_obi2axi.sv
// Ibex OBI port (instruction or data) to AXI4 master, several outstanding
// transactions, responses returned to the core strictly in request order.
module iob_ibex_obi2axi
    import iob_ibex_axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int INTG_W    = 7,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8,
    parameter int AXI_ID    = 0,
    parameter int MAX_OUTST = 2,
    parameter bit WRITE_EN  = 1'b1,
    parameter bit INTG_GEN  = 1'b1
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-3:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [INTG_W-1:0] rdata_intg_o,
    output logic              err_o,
    iob_ibex_obi2axi_if.master axi
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic              rvalid_q, err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              room, is_wr, rd_req, wr_req, aw_hs, w_hs, rd_gnt, wr_gnt;
    logic              fifo_head, fifo_empty, fifo_full, r_pop, b_pop, pop;

    assign is_wr  = WRITE_EN & we_i;
    assign room   = cnt_q < CNT_W'(MAX_OUTST);
    assign rd_req = req_i & ~is_wr & room;
    assign wr_req = req_i & is_wr & room;

    // AW and W proceed independently; the grant waits for whichever finishes last.
    assign axi.arvalid = rd_req;
    assign axi.awvalid = wr_req & ~aw_done_q;
    assign axi.wvalid  = wr_req & ~w_done_q;
    assign aw_hs  = axi.awvalid & axi.awready;
    assign w_hs   = axi.wvalid & axi.wready;
    assign rd_gnt = rd_req & axi.arready;
    assign wr_gnt = wr_req & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign gnt_o  = cke_i & (rd_gnt | wr_gnt);

    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (gnt_o) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else if (cke_i) begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
        end
    end

    iob_ibex_resp_fifo #(.DEPTH(MAX_OUTST)) u_order (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .push_i (gnt_o),
        .data_i (is_wr),
        .pop_i  (pop),
        .head_o (fifo_head),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

    assign axi.rready = cke_i & ~fifo_empty & ~fifo_head;
    assign axi.bready = cke_i & ~fifo_empty & fifo_head;
    assign r_pop = axi.rvalid & axi.rready;
    assign b_pop = axi.bvalid & axi.bready;
    assign pop   = r_pop | b_pop;
    assign cnt_d = cnt_q + CNT_W'(gnt_o) - CNT_W'(pop);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else if (cke_i) begin
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= pop;
            if (pop) begin
                rdata_q <= r_pop ? axi.rdata : '0;
                err_q   <= resp_is_err(r_pop ? axi.rresp : axi.bresp);
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    // Idle integrity is zero so the reset state shows all-zero outputs.
    generate
        if (INTG_GEN) begin : g_intg
            logic [38:0] enc;
            logic        unused_enc;
            prim_secded_inv_39_32_enc u_enc (.data_i(rdata_q), .data_o(enc));
            assign rdata_intg_o = rvalid_q ? INTG_W'(enc[38:32]) : '0;
            assign unused_enc   = ^enc[31:0];
        end else begin : g_no_intg
            assign rdata_intg_o = '0;
        end
    endgenerate

    assign axi.araddr  = addr_i;
    assign axi.arid    = AXI_ID_W'(AXI_ID);
    assign axi.arlen   = '0;
    assign axi.arsize  = AXI_SIZE_W32;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = '0;
    assign axi.arqos   = '0;
    assign axi.arprot  = WRITE_EN ? AXI_PROT_DATA : AXI_PROT_INSTR;

    assign axi.awaddr  = WRITE_EN ? addr_i : '0;
    assign axi.awid    = AXI_ID_W'(AXI_ID);
    assign axi.awlen   = '0;
    assign axi.awsize  = AXI_SIZE_W32;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = '0;
    assign axi.awqos   = '0;
    assign axi.awprot  = AXI_PROT_DATA;
    assign axi.wdata   = WRITE_EN ? wdata_i : '0;
    assign axi.wstrb   = WRITE_EN ? be_i : '0;
    assign axi.wlast   = 1'b1;

    logic unused_in;
    assign unused_in = ^{axi.rid, axi.rlast, axi.bid, axi.rresp[0], axi.bresp[0], fifo_full};

endmodule

// File: tb/tb_iob_ibex_obi2axi.sv
// Bench for iob_ibex_obi2axi: vector table plus hand-written multi-cycle sequences,
// responses checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_iob_ibex_obi2axi;

    logic        clk_i = 1'b0;
    logic        cke_i, arst_i;
    logic        req_i, we_i, gnt_o, rvalid_o, err_o;
    logic [3:0]  be_i;
    logic [29:0] addr_i;
    logic [31:0] wdata_i, rdata_o;
    logic [6:0]  rdata_intg_o;
    logic        i_req, i_we, i_gnt, i_rvalid, i_err;
    logic [3:0]  i_be;
    logic [29:0] i_addr;
    logic [31:0] i_wdata, i_rdata;
    logic [6:0]  i_intg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    iob_ibex_obi2axi_if #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) axi_d ();
    iob_ibex_obi2axi_if #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) axi_i ();

    iob_ibex_obi2axi #(.MAX_OUTST(2), .WRITE_EN(1'b1)) u_dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .req_i(req_i), .we_i(we_i),
        .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rdata_intg_o(rdata_intg_o),
        .err_o(err_o), .axi(axi_d)
    );

    iob_ibex_obi2axi #(.MAX_OUTST(2), .WRITE_EN(1'b0)) u_ins (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .req_i(i_req), .we_i(i_we),
        .be_i(i_be), .addr_i(i_addr), .wdata_i(i_wdata), .gnt_o(i_gnt),
        .rvalid_o(i_rvalid), .rdata_o(i_rdata), .rdata_intg_o(i_intg),
        .err_o(i_err), .axi(axi_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [6:0]  intg;
    } exp_t;

    typedef struct {
        string       nm;
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [31:0] beat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    // Reference Hsiao (39,32) check bits with the Ibex inversion pattern.
    function automatic logic [6:0] ref_intg(input logic [31:0] d);
        logic [38:0] c;
        logic [6:0]  p;
        c    = {7'b0, d};
        p[0] = ^(c & 39'h002606BD25);
        p[1] = ^(c & 39'h00DEBA8050);
        p[2] = ^(c & 39'h00413D89AA);
        p[3] = ^(c & 39'h0031234ED1);
        p[4] = ^(c & 39'h00C2C1323B);
        p[5] = ^(c & 39'h002DCC624C);
        p[6] = ^(c & 39'h0098505586);
        return p ^ 7'h2A;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        x.intg  = ref_intg(d);
        sb.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_i = 0; we_i = 0; be_i = 0; addr_i = 0; wdata_i = 0;
        axi_d.arready = 0; axi_d.awready = 0; axi_d.wready = 0;
        axi_d.rvalid = 0; axi_d.rdata = 0; axi_d.rresp = 0; axi_d.rid = 0; axi_d.rlast = 1;
        axi_d.bvalid = 0; axi_d.bresp = 0; axi_d.bid = 0;
        i_req = 0; i_we = 0; i_be = 0; i_addr = 0; i_wdata = 0;
        axi_i.arready = 0; axi_i.awready = 0; axi_i.wready = 0;
        axi_i.rvalid = 0; axi_i.rdata = 0; axi_i.rresp = 0; axi_i.rid = 0; axi_i.rlast = 1;
        axi_i.bvalid = 0; axi_i.bresp = 0; axi_i.bid = 0;
    endtask

    // Response monitor for the data-mode instance.
    always @(negedge clk_i) begin
        if (!arst_i && rvalid_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rvalid: got rvalid_o=1 rdata=%0h, required no response", rdata_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rdata_o, e.rdata);
                check("rsp_err", 32'(err_o), 32'(e.err));
                check("rsp_intg", 32'(rdata_intg_o), 32'(e.intg));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{"rd_okay",   1'b0, 30'h0400_0001, 4'hF, 32'h0,         2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{"rd_decerr", 1'b0, 30'h0000_0010, 4'hF, 32'h0,         2'b11, 32'h1234_5678, 32'h1234_5678, 1'b1};
        vecs[2] = '{"wr_okay",   1'b1, 30'h0123_4567, 4'h3, 32'hA5A5_5A5A, 2'b00, 32'hBAD0_BAD0, 32'h0,         1'b0};
        vecs[3] = '{"wr_slverr", 1'b1, 30'h3FFF_FFFF, 4'hF, 32'hFFFF_FFFF, 2'b10, 32'hBAD1_BAD1, 32'h0,         1'b1};
        vecs[4] = '{"rd_exokay", 1'b0, 30'h0000_0000, 4'hF, 32'h0,         2'b01, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{"rd_slverr", 1'b0, 30'h2AAA_AAAA, 4'hF, 32'h0,         2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{"wr_decerr", 1'b1, 30'h1555_5555, 4'h8, 32'h0F0F_0F0F, 2'b11, 32'hBAD2_BAD2, 32'h0,         1'b1};

        arst_i = 1; cke_i = 1;
        idle();
        cyc(); cyc();
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_rvalid", 32'(rvalid_o), 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_intg", 32'(rdata_intg_o), 0);
        check("rst_valids", 32'({axi_d.arvalid, axi_d.awvalid, axi_d.wvalid}), 0);
        check("rst_readys", 32'({axi_d.rready, axi_d.bready}), 0);
        check("rst_attr", 32'({axi_d.arlen, axi_d.arsize, axi_d.arburst, axi_d.arprot, axi_d.wlast}),
              32'({8'h0, 3'b010, 2'b01, 3'b000, 1'b1}));
        check("rst_awattr", 32'({axi_d.awsize, axi_d.awburst, axi_d.awprot, axi_d.arid}),
              32'({3'b010, 2'b01, 3'b000, 1'b0}));
        arst_i = 0;

        // Table: one transaction at a time, beat returned one cycle after grant.
        foreach (vecs[k]) begin
            cyc();
            req_i = 1; we_i = vecs[k].we; addr_i = vecs[k].addr; be_i = vecs[k].be; wdata_i = vecs[k].wdata;
            axi_d.arready = 1; axi_d.awready = 1; axi_d.wready = 1;
            #1;
            check({vecs[k].nm, "_gnt"}, 32'(gnt_o), 1);
            if (vecs[k].we) begin
                check({vecs[k].nm, "_awaddr"}, 32'(axi_d.awaddr), 32'(vecs[k].addr));
                check({vecs[k].nm, "_wstrb"}, 32'(axi_d.wstrb), 32'(vecs[k].be));
                check({vecs[k].nm, "_wdata"}, axi_d.wdata, vecs[k].wdata);
            end else begin
                check({vecs[k].nm, "_araddr"}, 32'(axi_d.araddr), 32'(vecs[k].addr));
            end
            expect_rsp(vecs[k].exp_rdata, vecs[k].exp_err);
            cyc();
            req_i = 0; axi_d.arready = 0; axi_d.awready = 0; axi_d.wready = 0;
            axi_d.rdata = vecs[k].beat;
            if (vecs[k].we) begin
                axi_d.bvalid = 1; axi_d.bresp = vecs[k].resp;
            end else begin
                axi_d.rvalid = 1; axi_d.rresp = vecs[k].resp;
            end
            #1;
            check({vecs[k].nm, "_ready"}, 32'(vecs[k].we ? axi_d.bready : axi_d.rready), 1);
            cyc();
            axi_d.rvalid = 0; axi_d.bvalid = 0;
        end

        // Outstanding limit: two grants, third waits for a pop.
        cyc();
        req_i = 1; we_i = 0; addr_i = 30'h100; axi_d.arready = 1;
        #1; check("lim_gnt0", 32'(gnt_o), 1); expect_rsp(32'h1111_0001, 1'b0);
        cyc();
        addr_i = 30'h101;
        #1; check("lim_gnt1", 32'(gnt_o), 1); expect_rsp(32'h2222_0002, 1'b0);
        cyc();
        addr_i = 30'h102; axi_d.rvalid = 1; axi_d.rdata = 32'h1111_0001; axi_d.rresp = 2'b00;
        #1;
        check("lim_arvalid_full", 32'(axi_d.arvalid), 0);
        check("lim_gnt_full", 32'(gnt_o), 0);
        check("lim_rready", 32'(axi_d.rready), 1);
        cyc();
        axi_d.rvalid = 0;
        #1;
        check("lim_arvalid_room", 32'(axi_d.arvalid), 1);
        check("lim_gnt2", 32'(gnt_o), 1);
        expect_rsp(32'h3333_0003, 1'b0);
        cyc();
        req_i = 0; axi_d.arready = 0; axi_d.rvalid = 1; axi_d.rdata = 32'h2222_0002;
        cyc();
        axi_d.rdata = 32'h3333_0003;
        cyc();
        axi_d.rvalid = 0;

        // Reset with two reads outstanding.
        cyc();
        req_i = 1; addr_i = 30'h200; axi_d.arready = 1;
        #1; check("rstm_gnt0", 32'(gnt_o), 1);
        cyc();
        addr_i = 30'h201;
        #1; check("rstm_gnt1", 32'(gnt_o), 1);
        cyc();
        #1; check("rstm_full", 32'(axi_d.arvalid), 0);
        req_i = 0; axi_d.arready = 0; arst_i = 1;
        #1;
        check("rstm_rready", 32'(axi_d.rready), 0);
        check("rstm_rvalid", 32'(rvalid_o), 0);
        check("rstm_rdata", rdata_o, 0);
        check("rstm_intg", 32'(rdata_intg_o), 0);
        check("rstm_err_gnt", 32'({err_o, gnt_o}), 0);
        cyc();
        arst_i = 0;
        cyc();
        req_i = 1; addr_i = 30'h300; axi_d.arready = 1;
        #1; check("rstm_after_gnt0", 32'(gnt_o), 1); expect_rsp(32'h4444_0004, 1'b0);
        cyc();
        addr_i = 30'h301;
        #1; check("rstm_after_gnt1", 32'(gnt_o), 1); expect_rsp(32'h5555_0005, 1'b1);
        cyc();
        req_i = 0; axi_d.arready = 0; axi_d.rvalid = 1; axi_d.rdata = 32'h4444_0004; axi_d.rresp = 2'b00;
        cyc();
        axi_d.rdata = 32'h5555_0005; axi_d.rresp = 2'b11;
        cyc();
        axi_d.rvalid = 0; axi_d.rresp = 0;

        // Split write: W accepted three cycles before AW.
        cyc();
        req_i = 1; we_i = 1; be_i = 4'b0011; addr_i = 30'h400; wdata_i = 32'hCAFE_0001;
        axi_d.awready = 0; axi_d.wready = 1;
        #1;
        check("split_valids0", 32'({axi_d.awvalid, axi_d.wvalid}), 32'(2'b11));
        check("split_gnt0", 32'(gnt_o), 0);
        cyc();
        #1;
        check("split_wvalid1", 32'(axi_d.wvalid), 0);
        check("split_gnt1", 32'(gnt_o), 0);
        cyc();
        #1; check("split_gnt2", 32'({gnt_o, axi_d.wvalid, axi_d.awvalid}), 32'(3'b001));
        cyc();
        axi_d.awready = 1;
        #1;
        check("split_gnt3", 32'(gnt_o), 1);
        check("split_wstrb", 32'(axi_d.wstrb), 32'(4'b0011));
        expect_rsp(32'h0, 1'b0);
        cyc();
        be_i = 4'hF; wdata_i = 32'hCAFE_0002; addr_i = 30'h401;
        #1;
        check("split_next_wvalid", 32'(axi_d.wvalid), 1);
        check("split_next_gnt", 32'(gnt_o), 1);
        expect_rsp(32'h0, 1'b1);
        cyc();
        req_i = 0; we_i = 0; axi_d.awready = 0; axi_d.wready = 0; axi_d.bvalid = 1; axi_d.bresp = 2'b00;
        #1; check("split_bready0", 32'(axi_d.bready), 1);
        cyc();
        axi_d.bresp = 2'b10;
        #1; check("split_bready1", 32'(axi_d.bready), 1);
        cyc();
        axi_d.bvalid = 0; axi_d.bresp = 0;

        // Ordering: B arrives before the earlier read's R.
        cyc();
        req_i = 1; we_i = 0; addr_i = 30'h500; axi_d.arready = 1;
        #1; check("ord_gnt_rd", 32'(gnt_o), 1); expect_rsp(32'h7777_0007, 1'b0);
        cyc();
        we_i = 1; addr_i = 30'h501; wdata_i = 32'h0; be_i = 4'hF;
        axi_d.arready = 0; axi_d.awready = 1; axi_d.wready = 1;
        #1; check("ord_gnt_wr", 32'(gnt_o), 1); expect_rsp(32'h0, 1'b0);
        cyc();
        req_i = 0; we_i = 0; axi_d.awready = 0; axi_d.wready = 0; axi_d.bvalid = 1; axi_d.bresp = 2'b00;
        #1;
        check("ord_bready_stall0", 32'(axi_d.bready), 0);
        check("ord_rready_head", 32'(axi_d.rready), 1);
        cyc();
        #1; check("ord_bready_stall1", 32'(axi_d.bready), 0);
        cyc();
        axi_d.rvalid = 1; axi_d.rdata = 32'h7777_0007;
        #1; check("ord_bready_stall2", 32'(axi_d.bready), 0);
        cyc();
        axi_d.rvalid = 0;
        #1; check("ord_bready_go", 32'(axi_d.bready), 1);
        cyc();
        axi_d.bvalid = 0;

        // Clock enable low: no grant, no response acceptance.
        cyc();
        cke_i = 0; req_i = 1; addr_i = 30'h600; axi_d.arready = 1;
        #1;
        check("cke_gnt_off", 32'(gnt_o), 0);
        check("cke_arvalid", 32'(axi_d.arvalid), 1);
        cyc();
        cke_i = 1;
        #1; check("cke_gnt_on", 32'(gnt_o), 1); expect_rsp(32'h8888_0008, 1'b0);
        cyc();
        cke_i = 0; req_i = 0; axi_d.arready = 0; axi_d.rvalid = 1; axi_d.rdata = 32'h8888_0008;
        #1; check("cke_rready_off", 32'(axi_d.rready), 0);
        cyc();
        cke_i = 1;
        #1; check("cke_rready_on", 32'(axi_d.rready), 1);
        cyc();
        axi_d.rvalid = 0;

        // Instruction-mode instance: write requests are treated as reads.
        cyc();
        i_req = 1; i_we = 1; i_addr = 30'h0400_0001;
        axi_i.arready = 1; axi_i.awready = 1; axi_i.wready = 1;
        #1;
        check("ins_awwvalid", 32'({axi_i.awvalid, axi_i.wvalid}), 0);
        check("ins_arvalid", 32'(axi_i.arvalid), 1);
        check("ins_arprot", 32'(axi_i.arprot), 32'(3'b100));
        check("ins_araddr", 32'(axi_i.araddr), 32'h0400_0001);
        check("ins_gnt", 32'(i_gnt), 1);
        cyc();
        i_req = 0; i_we = 0; axi_i.arready = 0; axi_i.awready = 0; axi_i.wready = 0;
        axi_i.rvalid = 1; axi_i.rdata = 32'h1357_9BDF; axi_i.rresp = 2'b00;
        #1; check("ins_rready", 32'(axi_i.rready), 1);
        cyc();
        axi_i.rvalid = 0;
        #1;
        check("ins_rvalid", 32'(i_rvalid), 1);
        check("ins_rdata", i_rdata, 32'h1357_9BDF);
        check("ins_err", 32'(i_err), 0);
        check("ins_intg", 32'(i_intg), 32'(ref_intg(32'h1357_9BDF)));
        check("ins_awvalid_end", 32'(axi_i.awvalid), 0);

        for (int w = 0; w < 10 && sb.size() != 0; w++) cyc();
        check("sb_drained", 32'(sb.size()), 0);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
